// File: rtl/trig_pkg.sv
// Shared definitions for the hit latch sequencer: state encoding,
// default widths and a population-count helper.
package trig_pkg;

  localparam int DEF_WIDTH       = 48;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CLR_CYCLES  = 2;

  // Widest pattern the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WINDOW  = 3'd1,
    ST_EVAL    = 3'd2,
    ST_REPORT  = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_t;

  // Count of set bits, evaluated combinationally over the full vector.
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hit_sync_bank.sv
// Per-channel multi-stage synchroniser bringing the asynchronous latch
// outputs into the clk domain. Every stage resets to 0.
module hit_sync_bank #(
  parameter int WIDTH  = 48,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_chan
      logic [STAGES-1:0] stage_reg;

      // Shift this channel through its own synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= '0;
        else        stage_reg <= {stage_reg[STAGES-2:0], d[gi]};
      end

      assign q[gi] = stage_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/hit_latch_sequencer.sv
// Sequencer for a bank of edge-set hit latches: waits for the first
// unmasked hit, collects hits over a coincidence window, evaluates the
// pattern against a threshold, reports accepted events on a valid/ready
// port, then clears the latches and waits out a dead time.
module hit_latch_sequencer
  import trig_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int CLR_CYCLES  = DEF_CLR_CYCLES,
  localparam int TH_W        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] latch_q,
  input  logic [WIDTH-1:0] chan_mask,
  input  logic [TH_W-1:0]  threshold,
  input  logic [CNT_W-1:0] window_len,
  input  logic [CNT_W-1:0] holdoff_len,
  output logic [WIDTH-1:0] latch_rst,
  output logic [WIDTH-1:0] evt_pattern,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             trig_out,
  output logic             busy,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] rej_count
);

  localparam int              CLR_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  // Dead time must at least cover the synchroniser so stale ones drain.
  localparam logic [CNT_W-1:0] MIN_HOLD = CNT_W'(SYNC_STAGES + 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hits;
  logic [WIDTH-1:0] eval_pattern;
  logic [TH_W-1:0]  pop_cnt;
  logic [TH_W-1:0]  thr_eff;
  logic             accept;
  logic [CNT_W-1:0] hold_len;

  logic [CNT_W-1:0] wcnt_reg, wcnt_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CLR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic [CNT_W-1:0] evt_count_reg, evt_count_next;
  logic [CNT_W-1:0] rej_count_reg, rej_count_next;
  logic             trig_reg, trig_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             clr_active_reg, clr_active_next;

  hit_sync_bank #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (latch_q),
    .q     (sync_q)
  );

  assign hits         = sync_q & chan_mask;
  assign eval_pattern = acc_reg | hits;
  assign pop_cnt      = TH_W'(popcount(POP_MAX_W'(eval_pattern)));
  assign thr_eff      = (threshold == '0) ? TH_W'(1) : threshold;
  assign accept       = (pop_cnt >= thr_eff);
  assign hold_len     = (holdoff_len > MIN_HOLD) ? holdoff_len : MIN_HOLD;

  // State register; reset lands in CLEAR so the latches get wiped first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_CLEAR;
    else        state_reg <= state_next;
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (enable && |hits) state_next = ST_WINDOW;
      ST_WINDOW:  if (wcnt_reg == '0) state_next = ST_EVAL;
      ST_EVAL:    state_next = accept ? ST_REPORT : ST_CLEAR;
      ST_REPORT:  if (valid_reg && evt_ready) state_next = ST_CLEAR;
      ST_CLEAR:   if (clr_active_reg && clr_cnt_reg == CLR_LAST) state_next = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt_reg == '0) state_next = ST_IDLE;
      default:    state_next = ST_CLEAR;
    endcase
  end

  // Datapath and registered-output next values; outputs track state_next
  // so they line up with the state they belong to.
  always_comb begin
    wcnt_next       = wcnt_reg;
    acc_next        = acc_reg;
    clr_cnt_next    = clr_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    pattern_next    = pattern_reg;
    evt_count_next  = evt_count_reg;
    rej_count_next  = rej_count_reg;
    trig_next       = 1'b0;
    valid_next      = (state_next == ST_REPORT);
    busy_next       = (state_next != ST_IDLE);
    clr_active_next = (state_next == ST_CLEAR);
    case (state_reg)
      ST_IDLE: begin
        if (state_next == ST_WINDOW) begin
          wcnt_next = window_len;
          acc_next  = hits;
        end
      end
      ST_WINDOW: begin
        acc_next = acc_reg | hits;
        if (wcnt_reg != '0) wcnt_next = wcnt_reg - CNT_W'(1);
      end
      ST_EVAL: begin
        if (accept) begin
          pattern_next   = eval_pattern;
          trig_next      = 1'b1;
          evt_count_next = evt_count_reg + CNT_W'(1);
        end else begin
          rej_count_next = rej_count_reg + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        acc_next = '0;
        // The first CLEAR cycle after reset has latch_rst still low, so
        // only cycles with the clear actually driven are counted.
        if (clr_active_reg) clr_cnt_next = clr_cnt_reg + CLR_W'(1);
        if (state_next == ST_HOLDOFF) begin
          clr_cnt_next  = '0;
          hold_cnt_next = hold_len - CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_reg != '0) hold_cnt_next = hold_cnt_reg - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears everything mid-event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg       <= '0;
      acc_reg        <= '0;
      clr_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      pattern_reg    <= '0;
      evt_count_reg  <= '0;
      rej_count_reg  <= '0;
      trig_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      clr_active_reg <= 1'b0;
    end else begin
      wcnt_reg       <= wcnt_next;
      acc_reg        <= acc_next;
      clr_cnt_reg    <= clr_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      pattern_reg    <= pattern_next;
      evt_count_reg  <= evt_count_next;
      rej_count_reg  <= rej_count_next;
      trig_reg       <= trig_next;
      valid_reg      <= valid_next;
      busy_reg       <= busy_next;
      clr_active_reg <= clr_active_next;
    end
  end

  assign latch_rst   = {WIDTH{clr_active_reg}};
  assign evt_pattern = pattern_reg;
  assign evt_valid   = valid_reg;
  assign trig_out    = trig_reg;
  assign busy        = busy_reg;
  assign evt_count   = evt_count_reg;
  assign rej_count   = rej_count_reg;

endmodule

// File: tb/tb_hit_latch_sequencer.sv
// Directed bench for hit_latch_sequencer with a behavioural latch bank
// and a queue of expected event patterns.
module tb_hit_latch_sequencer;

  localparam int WIDTH = 48;
  localparam int CNT_W = 8;
  localparam int TH_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] latch_q = '0;
  logic [WIDTH-1:0] set_pend = '0;
  logic [WIDTH-1:0] chan_mask = '1;
  logic [TH_W-1:0]  threshold = 6'd2;
  logic [CNT_W-1:0] window_len = 8'd3;
  logic [CNT_W-1:0] holdoff_len = 8'd0;
  logic [WIDTH-1:0] latch_rst;
  logic [WIDTH-1:0] evt_pattern;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic             trig_out;
  logic             busy;
  logic [CNT_W-1:0] evt_count;
  logic [CNT_W-1:0] rej_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int trig_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ones = '1;

  hit_latch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .latch_q     (latch_q),
    .chan_mask   (chan_mask),
    .threshold   (threshold),
    .window_len  (window_len),
    .holdoff_len (holdoff_len),
    .latch_rst   (latch_rst),
    .evt_pattern (evt_pattern),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .trig_out    (trig_out),
    .busy        (busy),
    .evt_count   (evt_count),
    .rej_count   (rej_count)
  );

  always #5 clk = ~clk;

  // Edge-set latch bank: set requests win over the clear.
  always @(posedge clk) latch_q <= (latch_q & ~latch_rst) | set_pend;

  // Count cycles with trig_out high.
  always @(negedge clk) if (trig_out === 1'b1) trig_cnt <= trig_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] bit_of(input int ch);
    logic [WIDTH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  task automatic pulse_hit(input int ch);
    set_pend = bit_of(ch);
    @(negedge clk);
    set_pend = '0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_clear(input int budget);
    int n;
    n = 0;
    while (latch_rst !== ones && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("clear_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  // Take the head of the scoreboard and compare it with the presented event.
  task automatic score_event(input string tag);
    logic [WIDTH-1:0] exp_pat;
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    exp_pat = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_pattern"}, 64'(evt_pattern), 64'(exp_pat));
    $display("event %s: pattern %012h count %0d", tag, evt_pattern, evt_count);
  endtask

  task automatic handshake(input string tag);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(evt_valid), 64'd0);
    check({tag, "_clear_start"}, 64'(latch_rst), 64'(ones));
  endtask

  initial begin
    int t0;
    logic [WIDTH-1:0] held;

    // 1: reset and power-up clear
    repeat (3) @(negedge clk);
    check("rst_latch_rst", 64'(latch_rst), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_evt_count", 64'(evt_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pwr_clr_c1", 64'(latch_rst), 64'(ones));
    check("pwr_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    check("pwr_clr_c2", 64'(latch_rst), 64'(ones));
    @(negedge clk);
    check("pwr_clr_c3", 64'(latch_rst), 64'd0);
    check("pwr_busy_c3", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("pwr_busy_c5", 64'(busy), 64'd1);
    @(negedge clk);
    check("pwr_idle_c6", 64'(busy), 64'd0);
    check("pwr_valid_c6", 64'(evt_valid), 64'd0);
    $display("step reset: idle reached");

    // 2 + 4: two-channel coincidence, then a 20-cycle stall on ready
    enable = 1'b1; threshold = 6'd2; window_len = 8'd3;
    t0 = trig_cnt;
    exp_q.push_back(bit_of(5) | bit_of(9));
    pulse_hit(5);
    @(negedge clk);
    pulse_hit(9);
    wait_valid(60);
    score_event("coinc");
    held = evt_pattern;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(evt_valid), 64'd1);
      check("stall_pattern", 64'(evt_pattern), 64'(held));
      check("stall_no_clear", 64'(latch_rst), 64'd0);
    end
    check("coinc_trig", 64'(trig_cnt - t0), 64'd1);
    check("coinc_evt_count", 64'(evt_count), 64'd1);
    handshake("coinc");
    wait_idle(60);
    check("coinc_latches_clear", 64'(latch_q), 64'd0);

    // 3: single hit below threshold is rejected
    threshold = 6'd3; window_len = 8'd1;
    t0 = trig_cnt;
    pulse_hit(0);
    wait_clear(60);
    wait_idle(60);
    check("rej_count", 64'(rej_count), 64'd1);
    check("rej_evt_count", 64'(evt_count), 64'd1);
    check("rej_trig", 64'(trig_cnt - t0), 64'd0);
    check("rej_latches_clear", 64'(latch_q), 64'd0);
    $display("step reject: rej_count %0d", rej_count);

    // 5: masked channel alone does not open a window
    threshold = 6'd1; window_len = 8'd3;
    chan_mask = ~bit_of(7);
    t0 = trig_cnt;
    pulse_hit(7);
    repeat (15) @(negedge clk);
    check("mask_busy", 64'(busy), 64'd0);
    check("mask_trig", 64'(trig_cnt - t0), 64'd0);
    check("mask_latched", 64'(latch_q[7]), 64'd1);
    exp_q.push_back(bit_of(3));
    pulse_hit(3);
    wait_valid(60);
    score_event("mask");
    handshake("mask");
    wait_idle(60);
    check("mask_evt_count", 64'(evt_count), 64'd2);
    check("mask_ch7_cleared", 64'(latch_q), 64'd0);
    chan_mask = '1;

    // Boundary: window_len=0 and threshold=0 (treated as 1)
    threshold = 6'd0; window_len = 8'd0;
    exp_q.push_back(bit_of(47));
    pulse_hit(47);
    wait_valid(60);
    score_event("edge");
    handshake("edge");
    wait_idle(60);
    check("edge_evt_count", 64'(evt_count), 64'd3);

    // 6: reset asserted while reporting
    threshold = 6'd1; window_len = 8'd2;
    exp_q.push_back(bit_of(11));
    pulse_hit(11);
    wait_valid(60);
    score_event("abort");
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(evt_valid), 64'd0);
    check("abort_evt_count", 64'(evt_count), 64'd0);
    check("abort_rej_count", 64'(rej_count), 64'd0);
    check("abort_pattern", 64'(evt_pattern), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_clear_c1", 64'(latch_rst), 64'(ones));
    wait_idle(60);
    check("abort_latches_clear", 64'(latch_q), 64'd0);
    check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("step abort: idle after reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
